// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory and its load/store front end.
package dmem_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_LANES = WORD_W / 8;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Picks the addressed lane(s) out of a raw array word and extends to a full word.
  function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                    input logic [2:0]        funct3,
                                                    input logic [1:0]        off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h000000, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0000, h};
      F3_W:    return word;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word array with per-lane write enables and a registered read port; stands in for an SRAM macro.
module dmem_byte_ram #(
  parameter int WORD_AW   = 9,
  parameter int NUM_LANES = 4
) (
  input  logic                   clk,
  input  logic [WORD_AW-1:0]     addr_i,
  input  logic [NUM_LANES-1:0]   we_i,
  input  logic [NUM_LANES*8-1:0] wdata_i,
  input  logic                   re_i,
  output logic [NUM_LANES*8-1:0] rdata_o
);

  logic [NUM_LANES*8-1:0] mem_q [2**WORD_AW];
  logic [NUM_LANES*8-1:0] rdata_q;

  // NOTE: the array has no reset on purpose; clearing it would block mapping onto an SRAM macro.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we_i[l]) mem_q[addr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
    end
    // Read register only moves on a load so a stalled response keeps its data.
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store front end: valid/ready request, lane select and extension, back-pressurable response.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  if (DATA_W != WORD_W) begin : g_bad_data_w
    $error("dmem_lsu: DATA_W must be 32");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("dmem_lsu: READ_LAT must be 1 or 2");
  end

  state_e                 state_q, state_d;
  logic                   accept;
  logic [1:0]             off;
  logic                   illegal;
  logic                   req_err;
  logic [NUM_LANES-1:0]   lane_we;
  logic [DATA_W-1:0]      lane_wdata;
  logic [DATA_W-1:0]      ram_rdata;
  logic [DATA_W-1:0]      ext_word;
  logic [DATA_W-1:0]      rsp_word;

  logic                   we_q;
  logic                   err_q;
  logic [2:0]             f3_q;
  logic [1:0]             off_q;
  logic [DATA_W-1:0]      lat2_q;

  assign off    = req_addr[1:0];
  assign accept = req_valid && req_ready;

  always_comb begin
    illegal = 1'b0;
    if (req_we) illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else        illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

  assign req_err = illegal || is_misaligned(req_funct3, off);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    lane_we    = '0;
    lane_wdata = req_wdata;
    if (accept && req_we && !req_err) begin
      case (req_funct3)
        F3_B: begin
          lane_we    = NUM_LANES'(1) << off;
          lane_wdata = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          lane_we    = off[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{req_wdata[15:0]}};
        end
        F3_W:    lane_we = '1;
        default: lane_we = '0;
      endcase
    end
  end

  dmem_byte_ram #(
    .WORD_AW   (ADDR_W - 2),
    .NUM_LANES (NUM_LANES)
  ) u_ram (
    .clk     (clk),
    .addr_i  (req_addr[ADDR_W-1:2]),
    .we_i    (lane_we),
    .wdata_i (lane_wdata),
    .re_i    (accept && !req_we),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (READ_LAT == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ext_word = load_extend(ram_rdata, f3_q, off_q);
  assign rsp_word = (READ_LAT == 2) ? lat2_q : ext_word;

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      lat2_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= req_err;
        f3_q  <= req_funct3;
        off_q <= off;
      end
      if (state_q == ST_WAIT) lat2_q <= ext_word;
    end
  end

  // Stores and faulting requests answer with zero data.
  assign rsp_rdata = (state_q == ST_RESP && !we_q && !err_q) ? rsp_word : '0;
  assign rsp_err   = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: runs one READ_LAT=1 and one READ_LAT=2 instance against a vector table and corner sequences.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [10:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(11), .DATA_W(32), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_lsu #(.ADDR_W(11), .DATA_W(32), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void add_vec(input logic we, input logic [2:0] f3, input logic [10:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = erd; v.exp_err = eerr;
    vecs.push_back(v);
  endfunction

  // Response monitor: pops the scoreboard whenever a response handshake is about to complete.
  always @(negedge clk) begin
    if (rst_n && rsp_valid[0] && rsp_ready[0]) begin
      if (sb0.size() == 0) check("rsp0_unexpected", 32'(sb0.size()), 32'd1);
      else begin
        e0 = sb0.pop_front();
        check("rsp0_rdata", rsp_rdata[0], e0.rdata);
        check("rsp0_err", 32'(rsp_err[0]), 32'(e0.err));
      end
    end
    if (rst_n && rsp_valid[1] && rsp_ready[1]) begin
      if (sb1.size() == 0) check("rsp1_unexpected", 32'(sb1.size()), 32'd1);
      else begin
        e1 = sb1.pop_front();
        check("rsp1_rdata", rsp_rdata[1], e1.rdata);
        check("rsp1_err", 32'(rsp_err[1]), 32'(e1.err));
      end
    end
  end

  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic send(input int sel, input logic we, input logic [2:0] f3, input logic [10:0] addr,
                      input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                      input bit track, output int acc_cyc);
    exp_t e;
    int   waited;
    waited = 0;
    while (!req_ready[sel] && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready[sel]) begin
      check("req_ready_timeout", 32'(req_ready[sel]), 32'd1);
      acc_cyc = -1;
      return;
    end
    req_valid[sel]  = 1'b1;
    req_we[sel]     = we;
    req_funct3[sel] = f3;
    req_addr[sel]   = addr;
    req_wdata[sel]  = wdata;
    @(posedge clk); #1;
    req_valid[sel]  = 1'b0;
    req_wdata[sel]  = 32'h0BAD_0BAD;
    acc_cyc = cyc;
    if (track) begin
      e.rdata = erd;
      e.err   = eerr;
      if (sel == 0) sb0.push_back(e);
      else          sb1.push_back(e);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_sb0", 32'(sb0.size()), 32'd0);
    check("drain_sb1", 32'(sb1.size()), 32'd0);
  endtask

  initial begin
    int a0, a1, a2;

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_funct3[s] = 3'b000;
      req_addr[s] = '0; req_wdata[s] = '0; rsp_ready[s] = 1'b1;
    end

    add_vec(1'b1, F3_W,   11'h010, 32'hDEADBEEF, 32'h00000000, 1'b0);
    add_vec(1'b0, F3_BU,  11'h013, 32'h0,        32'h000000DE, 1'b0);
    add_vec(1'b0, F3_B,   11'h010, 32'h0,        32'hFFFFFFEF, 1'b0);
    add_vec(1'b0, F3_B,   11'h011, 32'h0,        32'hFFFFFFBE, 1'b0);
    add_vec(1'b0, F3_BU,  11'h012, 32'h0,        32'h000000AD, 1'b0);
    add_vec(1'b0, F3_HU,  11'h010, 32'h0,        32'h0000BEEF, 1'b0);
    add_vec(1'b0, F3_H,   11'h012, 32'h0,        32'hFFFFDEAD, 1'b0);
    add_vec(1'b0, F3_HU,  11'h012, 32'h0,        32'h0000DEAD, 1'b0);
    add_vec(1'b0, F3_W,   11'h010, 32'h0,        32'hDEADBEEF, 1'b0);
    add_vec(1'b1, F3_W,   11'h020, 32'h11223344, 32'h00000000, 1'b0);
    add_vec(1'b1, F3_B,   11'h021, 32'hFFFFFFAA, 32'h00000000, 1'b0);
    add_vec(1'b1, F3_H,   11'h022, 32'h12345566, 32'h00000000, 1'b0);
    add_vec(1'b0, F3_W,   11'h020, 32'h0,        32'h5566AA44, 1'b0);
    add_vec(1'b1, F3_W,   11'h000, 32'h01234567, 32'h00000000, 1'b0);
    add_vec(1'b0, F3_W,   11'h006, 32'h0,        32'h00000000, 1'b1);
    add_vec(1'b1, F3_H,   11'h003, 32'h0000FFFF, 32'h00000000, 1'b1);
    add_vec(1'b0, F3_W,   11'h000, 32'h0,        32'h01234567, 1'b0);
    add_vec(1'b0, 3'b011, 11'h000, 32'h0,        32'h00000000, 1'b1);
    add_vec(1'b0, 3'b110, 11'h004, 32'h0,        32'h00000000, 1'b1);
    add_vec(1'b0, F3_H,   11'h011, 32'h0,        32'h00000000, 1'b1);
    add_vec(1'b1, F3_BU,  11'h000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    add_vec(1'b0, F3_W,   11'h000, 32'h0,        32'h01234567, 1'b0);
    add_vec(1'b1, F3_W,   11'h7FC, 32'hA5A55A5A, 32'h00000000, 1'b0);
    add_vec(1'b0, F3_B,   11'h7FF, 32'h0,        32'hFFFFFFA5, 1'b0);
    add_vec(1'b0, F3_H,   11'h7FE, 32'h0,        32'hFFFFA5A5, 1'b0);
    add_vec(1'b0, F3_W,   11'h7FC, 32'h0,        32'hA5A55A5A, 1'b0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d_req_ready", s), 32'(req_ready[s]), 32'd1);
      check($sformatf("reset%0d_rsp_valid", s), 32'(rsp_valid[s]), 32'd0);
      check($sformatf("reset%0d_rsp_rdata", s), rsp_rdata[s], 32'd0);
      check($sformatf("reset%0d_rsp_err", s), 32'(rsp_err[s]), 32'd0);
    end

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < vecs.size(); i++) begin
        send(s, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, 1'b1, a0);
      end
    end
    drain();

    // Back-pressure: the response must hold still while the consumer stalls.
    rsp_ready[0] = 1'b0;
    send(0, 1'b0, F3_W, 11'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, a0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("stall_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("stall_req_ready", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("release_req_ready", 32'(req_ready[0]), 32'd1);
    drain();

    // Latency and back-to-back throughput for both READ_LAT settings.
    for (int s = 0; s < 2; s++) begin
      send(s, 1'b0, F3_W, 11'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, a0);
      check($sformatf("lat%0d_valid_T1", s + 1), 32'(rsp_valid[s]), (s == 0) ? 32'd1 : 32'd0);
      if (s == 1) begin
        @(posedge clk); #1;
        check("lat2_valid_T2", 32'(rsp_valid[1]), 32'd1);
      end
      send(s, 1'b0, F3_HU, 11'h012, 32'h0, 32'h0000DEAD, 1'b0, 1'b1, a1);
      send(s, 1'b0, F3_B,  11'h7FF, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b1, a2);
      check($sformatf("lat%0d_spacing_a", s + 1), 32'(a1 - a0), 32'(s + 2));
      check($sformatf("lat%0d_spacing_b", s + 1), 32'(a2 - a1), 32'(s + 2));
    end
    drain();

    // Reset with a store response pending: response dropped, store retained.
    send(0, 1'b1, F3_W, 11'h040, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, a0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    check("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
    send(0, 1'b0, F3_W, 11'h040, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, a0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
